// File: rtl/flags_sched_pkg.sv
// Shared definitions for the flags scheduler: flag bit positions, condition codes,
// FSM states and the masked flag-merge helper used by both commit paths.
package flags_sched_pkg;

   localparam int FLAGS_W = 5;

   localparam int FLAG_Q = 4;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

   // mask[1] replaces N,Z; mask[0] replaces C,V and ORs the sticky Q bit in.
   function automatic logic [FLAGS_W-1:0] merge_flags(
      input logic [FLAGS_W-1:0] cur,
      input logic [FLAGS_W-1:0] upd,
      input logic [1:0]         mask
   );
      logic [FLAGS_W-1:0] res;
      res = cur;
      if (mask[1]) begin
         res[FLAG_N] = upd[FLAG_N];
         res[FLAG_Z] = upd[FLAG_Z];
      end
      if (mask[0]) begin
         res[FLAG_C] = upd[FLAG_C];
         res[FLAG_V] = upd[FLAG_V];
         res[FLAG_Q] = cur[FLAG_Q] | upd[FLAG_Q];
      end
      return res;
   endfunction

endpackage

// File: rtl/flags_sched_if.sv
// Bundle between decode/EX control, the ALU/multiplier flag outputs and the
// flags scheduler; master is the pipeline side, slave is flags_sched.
interface flags_sched_if;
   import flags_sched_pkg::*;

   logic               ex_valid;
   logic [3:0]         ex_cond;
   logic [1:0]         ex_flags_write;
   logic               ex_multi;
   logic [FLAGS_W-1:0] alu_flags;
   logic               mul_done;
   logic [FLAGS_W-1:0] mul_flags;
   logic               q_clear;
   logic               cond_ex;
   logic               stall;
   logic               illegal_cond;
   logic [FLAGS_W-1:0] flags;

   modport master (
      output ex_valid, ex_cond, ex_flags_write, ex_multi, alu_flags,
             mul_done, mul_flags, q_clear,
      input  cond_ex, stall, illegal_cond, flags
   );

   modport slave (
      input  ex_valid, ex_cond, ex_flags_write, ex_multi, alu_flags,
             mul_done, mul_flags, q_clear,
      output cond_ex, stall, illegal_cond, flags
   );
endinterface

// File: rtl/flags_sched_cond_eval.sv
// Purely combinational ARM condition-code table; the Q bit never takes part,
// so only {N,Z,C,V} come in. Code 1111 fails and is flagged illegal.
module flags_sched_cond_eval
   import flags_sched_pkg::*;
(
   input  logic [3:0] nzcv,
   input  logic [3:0] cond,
   output logic       pass,
   output logic       illegal
);

   logic n, z, c, v;

   always_comb begin
      n       = nzcv[3];
      z       = nzcv[2];
      c       = nzcv[1];
      v       = nzcv[0];
      pass    = 1'b0;
      illegal = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c & !z;
         COND_LS: pass = !c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/flags_sched.sv
// Flags register, pending multi-cycle flag tracking and EX stall generation.
// Optional FLAGS_SCHED_BYPASS_EN lets the waiting instruction use mul flags in the mul_done cycle.
module flags_sched
   import flags_sched_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   flags_sched_if.slave bus
);

   state_e             state_q, state_d;
   logic [1:0]         pend_mask_q, pend_mask_d;
   logic [FLAGS_W-1:0] flags_q, flags_d;
   logic               illegal_q, illegal_d;

   logic [FLAGS_W-1:0] merged_flags;
   logic [3:0]         eval_nzcv;
   logic               mul_land;
   logic               pend_block;
   logic               stall;
   logic               cond_pass;
   logic               cond_illegal;
   logic               accepted;
   logic               ex_commit;

   assign mul_land     = (state_q == ST_PENDING) & bus.mul_done;
   assign merged_flags = merge_flags(flags_q, bus.mul_flags, pend_mask_q);
   // Only unconditional, non-flag-setting instructions may slip past a pending write.
   assign pend_block   = bus.ex_valid &
                         ((bus.ex_cond != COND_AL) | (bus.ex_flags_write != 2'b00));

`ifdef FLAGS_SCHED_BYPASS_EN
   assign eval_nzcv = mul_land ? merged_flags[3:0] : flags_q[3:0];
   assign stall     = (state_q == ST_PENDING) & !bus.mul_done & pend_block;
`else
   assign eval_nzcv = flags_q[3:0];
   assign stall     = (state_q == ST_PENDING) & pend_block;
`endif

   flags_sched_cond_eval u_cond_eval (
      .nzcv    (eval_nzcv),
      .cond    (bus.ex_cond),
      .pass    (cond_pass),
      .illegal (cond_illegal)
   );

   assign accepted  = bus.ex_valid & !stall;
   assign ex_commit = accepted & cond_pass & (bus.ex_flags_write != 2'b00);

   always_comb begin
      state_d     = state_q;
      pend_mask_d = pend_mask_q;
      flags_d     = flags_q;
      illegal_d   = accepted & cond_illegal;

      if (mul_land) begin
         flags_d     = merged_flags;
         state_d     = ST_IDLE;
         pend_mask_d = 2'b00;
      end

      // An EX write lands on top of any multiplier flags retiring this cycle.
      if (ex_commit) begin
         if (bus.ex_multi) begin
            pend_mask_d = bus.ex_flags_write;
            state_d     = ST_PENDING;
         end else begin
            flags_d = merge_flags(flags_d, bus.alu_flags, bus.ex_flags_write);
         end
      end

      if (bus.q_clear) begin
         flags_d[FLAG_Q] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         pend_mask_q <= 2'b00;
         flags_q     <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_mask_q <= pend_mask_d;
         flags_q     <= flags_d;
         illegal_q   <= illegal_d;
      end
   end

   assign bus.cond_ex      = cond_pass;
   assign bus.stall        = stall;
   assign bus.illegal_cond = illegal_q;
   assign bus.flags        = flags_q;

endmodule

// File: tb/tb_flags_sched.sv
// Directed bench for flags_sched: a vector table for single-cycle behaviour plus
// hand-written sequences for multiplier pending, reset mid-pending and bypass.
module tb_flags_sched;
   import flags_sched_pkg::*;

`ifdef FLAGS_SCHED_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      string      name;
      logic       valid;
      logic [3:0] cond;
      logic [1:0] fw;
      logic       multi;
      logic [4:0] alu;
      logic       md;
      logic [4:0] mf;
      logic       qc;
      logic       exp_cond;
      logic       exp_stall;
      logic [4:0] exp_flags;
      logic       exp_ill;
   } vec_t;

   logic clk;
   logic reset_n;
   int   check_count;
   int   pass_count;

   flags_sched_if bus();

   flags_sched dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(string name, logic valid, logic [3:0] cond, logic [1:0] fw,
                               logic multi, logic [4:0] alu, logic md, logic [4:0] mf,
                               logic qc, logic exp_cond, logic exp_stall,
                               logic [4:0] exp_flags, logic exp_ill);
      vec_t v;
      v.name = name;  v.valid = valid; v.cond = cond;   v.fw = fw;
      v.multi = multi; v.alu = alu;    v.md = md;       v.mf = mf;
      v.qc = qc;      v.exp_cond = exp_cond; v.exp_stall = exp_stall;
      v.exp_flags = exp_flags; v.exp_ill = exp_ill;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.ex_valid       = v.valid;
      bus.ex_cond        = v.cond;
      bus.ex_flags_write = v.fw;
      bus.ex_multi       = v.multi;
      bus.alu_flags      = v.alu;
      bus.mul_done       = v.md;
      bus.mul_flags      = v.mf;
      bus.q_clear        = v.qc;
   endtask

   // Drive at the falling edge, check combinational outputs before the rising edge,
   // then check registered outputs just after it.
   task automatic runVec(input vec_t v);
      @(negedge clk);
      applyStimulus(v);
      #1;
      checkOutput({v.name, ".cond_ex"}, {7'd0, bus.cond_ex}, {7'd0, v.exp_cond});
      checkOutput({v.name, ".stall"},   {7'd0, bus.stall},   {7'd0, v.exp_stall});
      @(posedge clk);
      #1;
      checkOutput({v.name, ".flags"},   {3'd0, bus.flags},   {3'd0, v.exp_flags});
      checkOutput({v.name, ".illegal"}, {7'd0, bus.illegal_cond}, {7'd0, v.exp_ill});
   endtask

   vec_t vecs[$];

   initial begin
      check_count = 0;
      pass_count  = 0;
      reset_n     = 1'b1;
      applyStimulus(mk("idle", 0, COND_AL, 2'b00, 0, 5'b0, 0, 5'b0, 0, 0, 0, 5'b0, 0));

      // Asynchronous reset asserted mid-cycle
      #12 reset_n = 1'b0;
      #1;
      checkOutput("rst.flags",   {3'd0, bus.flags}, 8'd0);
      checkOutput("rst.stall",   {7'd0, bus.stall}, 8'd0);
      checkOutput("rst.illegal", {7'd0, bus.illegal_cond}, 8'd0);
      checkOutput("rst.cond_al", {7'd0, bus.cond_ex}, 8'd1);
      bus.ex_cond = COND_EQ;
      #1;
      checkOutput("rst.cond_eq", {7'd0, bus.cond_ex}, 8'd0);
      @(negedge clk);
      reset_n = 1'b1;

      //          name    v  cond     fw     m  alu       md mf        qc cex stl flags     ill
      vecs.push_back(mk("v00_idle", 0, COND_AL, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b00000, 0));
      vecs.push_back(mk("v01_eq0",  0, COND_EQ, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 5'b00000, 0));
      vecs.push_back(mk("v02_subs", 1, COND_AL, 2'b11, 0, 5'b01100, 0, 5'b00000, 0, 1, 0, 5'b01100, 0));
      vecs.push_back(mk("v03_beq",  1, COND_EQ, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b01100, 0));
      vecs.push_back(mk("v04_ne",   1, COND_NE, 2'b11, 0, 5'b00011, 0, 5'b00000, 0, 0, 0, 5'b01100, 0));
      vecs.push_back(mk("v05_mi",   1, COND_MI, 2'b10, 0, 5'b00110, 0, 5'b00000, 0, 1, 0, 5'b00100, 0));
      vecs.push_back(mk("v06_cc",   1, COND_CC, 2'b01, 0, 5'b10011, 0, 5'b00000, 0, 1, 0, 5'b10111, 0));
      vecs.push_back(mk("v07_qclr", 1, COND_AL, 2'b01, 0, 5'b10000, 0, 5'b00000, 1, 1, 0, 5'b00100, 0));
      vecs.push_back(mk("v08_qset", 1, COND_AL, 2'b01, 0, 5'b10010, 0, 5'b00000, 0, 1, 0, 5'b10110, 0));
      vecs.push_back(mk("v09_qstk", 1, COND_AL, 2'b01, 0, 5'b00001, 0, 5'b00000, 0, 1, 0, 5'b10101, 0));
      vecs.push_back(mk("v10_ge",   1, COND_GE, 2'b11, 0, 5'b01000, 0, 5'b00000, 0, 0, 0, 5'b10101, 0));
      vecs.push_back(mk("v11_lt",   1, COND_LT, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b10101, 0));
      vecs.push_back(mk("v12_nv",   1, COND_NV, 2'b11, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 5'b10101, 1));
      vecs.push_back(mk("v13_post", 0, COND_AL, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b10101, 0));
      vecs.push_back(mk("v14_mdig", 0, COND_AL, 2'b00, 0, 5'b00000, 1, 5'b01111, 0, 1, 0, 5'b10101, 0));
      vecs.push_back(mk("v15_qc",   0, COND_AL, 2'b00, 0, 5'b00000, 0, 5'b00000, 1, 1, 0, 5'b00101, 0));
      vecs.push_back(mk("v16_gt",   1, COND_GT, 2'b11, 0, 5'b01000, 0, 5'b00000, 0, 0, 0, 5'b00101, 0));
      vecs.push_back(mk("v17_le",   1, COND_LE, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b00101, 0));
      vecs.push_back(mk("v18_hi",   1, COND_HI, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 5'b00101, 0));
      vecs.push_back(mk("v19_ls",   1, COND_LS, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b00101, 0));
      vecs.push_back(mk("v20_vc",   1, COND_VC, 2'b11, 0, 5'b11111, 0, 5'b00000, 0, 0, 0, 5'b00101, 0));
      vecs.push_back(mk("v21_cs",   1, COND_CS, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 5'b00101, 0));

      foreach (vecs[i]) runVec(vecs[i]);

      // MULS then a dependent ADDEQ waiting on the multiplier's N,Z
      runVec(mk("a0_set",   1, COND_AL, 2'b11, 0, 5'b01000, 0, 5'b00000, 0, 1, 0, 5'b01000, 0));
      runVec(mk("a1_muls",  1, COND_AL, 2'b10, 1, 5'b11111, 0, 5'b00000, 0, 1, 0, 5'b01000, 0));
      runVec(mk("a2_wait",  1, COND_EQ, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 5'b01000, 0));
      runVec(mk("a3_mdone", 1, COND_EQ, 2'b00, 0, 5'b00000, 1, 5'b00111, 0, BYP, !BYP, 5'b00100, 0));
      runVec(mk("a4_go",    1, COND_EQ, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b00100, 0));

      // PENDING: AL non-flag proceeds, AL flag-setting stalls
      runVec(mk("b1_mul",   1, COND_AL, 2'b01, 1, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b00100, 0));
      runVec(mk("b2_alnf",  1, COND_AL, 2'b00, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b00100, 0));
      runVec(mk("b3_alfs",  1, COND_AL, 2'b01, 0, 5'b00011, 0, 5'b00000, 0, 1, 1, 5'b00100, 0));
      runVec(mk("b4_mdone", 0, COND_AL, 2'b00, 0, 5'b00000, 1, 5'b10010, 0, 1, 0, 5'b10110, 0));
      runVec(mk("b5_after", 1, COND_AL, 2'b01, 0, 5'b00011, 0, 5'b00000, 0, 1, 0, 5'b10111, 0));

      // Reset while a multiplier write is pending
      runVec(mk("c1_mul",   1, COND_AL, 2'b11, 1, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b10111, 0));
      @(negedge clk);
      applyStimulus(mk("c_rst", 1, COND_EQ, 2'b00, 0, 5'b0, 0, 5'b0, 0, 0, 0, 5'b0, 0));
      #2 reset_n = 1'b0;
      #1;
      checkOutput("c_rst.flags", {3'd0, bus.flags}, 8'd0);
      checkOutput("c_rst.stall", {7'd0, bus.stall}, 8'd0);
      checkOutput("c_rst.cond",  {7'd0, bus.cond_ex}, 8'd0);
      @(negedge clk);
      reset_n = 1'b1;
      runVec(mk("c2_latemd", 0, COND_AL, 2'b00, 0, 5'b00000, 1, 5'b11111, 0, 1, 0, 5'b00000, 0));
      runVec(mk("c3_idle",   1, COND_AL, 2'b11, 0, 5'b00010, 0, 5'b00000, 0, 1, 0, 5'b00010, 0));

`ifdef FLAGS_SCHED_BYPASS_EN
      // EX write in the mul_done cycle lands on top of the merged flags
      runVec(mk("p1_mul",   1, COND_AL, 2'b01, 1, 5'b00000, 0, 5'b00000, 0, 1, 0, 5'b00010, 0));
      runVec(mk("p2_byp",   1, COND_AL, 2'b10, 0, 5'b01000, 1, 5'b10000, 0, 1, 0, 5'b11000, 0));
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/flags_sched.md
# flags_sched

Flag-register controller and condition scheduler for the pipeline execute stage. Owns the architectural 5-bit flags register {Q, N, Z, C, V}, evaluates each EX instruction's 4-bit condition against it, and commits ALU flag updates. Tracks flag writes from multi-cycle operations (multiplier) and stalls flag-dependent instructions until those flags land. Sits between decode/EX control and the ALU/multiplier flag outputs.

## Interface
- FLAGS_W, 5, flag vector width, fixed order {Q, N, Z, C, V} (bit 4..0)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ex_valid  in  1  valid instruction in EX
- ex_cond  in  4  condition code (ARM encoding, 0000 EQ .. 1110 AL)
- ex_flags_write  in  2  bit1: update N,Z; bit0: update C,V and OR-in Q
- ex_multi  in  1  EX op is multi-cycle; its flags come from mul_flags
- alu_flags  in  FLAGS_W  single-cycle ALU flags for EX instruction
- mul_done  in  1  one-cycle pulse, multi-cycle result ready
- mul_flags  in  FLAGS_W  multi-cycle flags, valid with mul_done
- q_clear  in  1  clear sticky Q
- cond_ex  out  1  EX condition passes (combinational)
- stall  out  1  hold EX this cycle (combinational)
- illegal_cond  out  1  registered pulse, ex_cond==1111 accepted
- flags  out  FLAGS_W  architectural flags register

## Operation
- Condition table: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 -> cond_ex=0, illegal_cond pulses next cycle.
- "Accepted" = ex_valid & !stall.
- FSM states: IDLE, PENDING.
- IDLE, accepted, cond_ex, ex_flags_write!=0, !ex_multi: commit alu_flags masked by write bits at edge.
- IDLE, accepted, cond_ex, ex_flags_write!=0, ex_multi: latch mask into pend_mask, -> PENDING; flags unchanged.
- Accepted with cond_ex=0 or write mask 0: no flag change, no state change.
- PENDING: stall=1 when ex_valid & (ex_cond!=AL | ex_flags_write!=0); AL non-flag-setting instructions proceed.
- PENDING, mul_done: commit mul_flags masked by pend_mask, -> IDLE, pend_mask<=0.
- Q: sticky; Q<=Q|new_Q when bit0 commits; q_clear forces Q=0 and wins over simultaneous set.
- mul_done in IDLE: ignored.

## Timing
- Reset: flags=0, state=IDLE, pend_mask=0, illegal_cond=0; stall and cond_ex follow from reset flags (cond_ex=1 for AL, EQ=0).
- Single-cycle flag update visible to the next EX instruction (1-cycle latency, no stall).
- Multi-cycle: stall deasserts the cycle after mul_done (without bypass).
- mul_done same cycle as a waiting EX instruction: see Configuration.
- Reset mid-PENDING: pending write discarded; late mul_done ignored.

## Configuration
- FLAGS_SCHED_BYPASS_EN defined: on mul_done in PENDING, cond_ex evaluates on merged flags (pend_mask applied to mul_flags), stall=0 that cycle; a flag-setting EX instruction in that cycle commits on top of merged flags (EX write wins per field).
- Undefined: stall held through the mul_done cycle; waiting instruction proceeds next cycle on committed flags.

## Structure
- flags_pkg: flag bit indices, cond-code localparams (COND_EQ..COND_AL), FSM state enum, FLAGS_W.
- Sub-module cond_eval: purely combinational condition table + illegal detect; flags_sched holds register, FSM, masking, stall.

## Test plan
- Reset: assert reset_n=0 mid-cycle -> flags=00000, stall=0, cond_ex=1 for AL, 0 for EQ.
- SUBS write=11, alu_flags=01100 then BEQ next cycle -> flags=01100, cond_ex=1, no stall.
- MULS ex_multi=1 write=10, then ADDEQ -> stall until mul_done with mul_flags=00100; bypass: proceeds in mul_done cycle; no bypass: one cycle later; flags=00100.
- PENDING with AL non-flag instruction -> stall=0; with AL write=01 -> stall=1.
- Q sticky: two commits bit0 with Q=1 then Q=0 -> Q stays 1; q_clear with simultaneous set -> Q=0.
- ex_cond=1111 accepted -> cond_ex=0, flags unchanged, illegal_cond=1 for exactly one cycle.
